// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, instruction codes and the
// stage-state encoding used by the SEQ sequencer.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_PCUPD,
        ST_HALT
    } stage_e;

    // Fetch fault priority: address error, then invalid instruction, then halt.
    function automatic logic [2:0] fetch_status(input logic imem_er,
                                                input logic inst_valid,
                                                input logic hlt_er);
        if (imem_er)
            return STAT_ADR;
        else if (!inst_valid)
            return STAT_INS;
        else if (hlt_er)
            return STAT_HLT;
        else
            return STAT_AOK;
    endfunction

endpackage

// File: rtl/seq_perf_counters.sv
// Pair of saturating performance counters (busy cycles, retired instructions)
// with a shared synchronous clear.
module seq_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc_cycle,
    input  logic             inc_instr,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    logic [1:0]            inc;
    logic [1:0][CNT_W-1:0] cnt_all;

    assign inc = {inc_instr, inc_cycle};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        // Counters stick at all-ones rather than wrapping.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt_reg <= '0;
            else if (clear)
                cnt_reg <= '0;
            else if (inc[gi] && !(&cnt_reg))
                cnt_reg <= cnt_reg + CNT_W'(1);
        end

        assign cnt_all[gi] = cnt_reg;
    end

    assign cycle_count = cnt_all[0];
    assign instr_count = cnt_all[1];

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle Y86-64 SEQ sequencer: owns PC and status, steps each instruction
// through six stages, waits on data memory with a timeout and counts activity.
module seq_stage_controller
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      start_pc,
    input  logic [3:0]       f_icode,
    input  logic             f_inst_valid,
    input  logic             f_imem_er,
    input  logic             f_hlt_er,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic             dmem_er,
    input  logic [63:0]      new_pc,
    output logic [63:0]      pc,
    output logic             en_fetch,
    output logic             en_decode,
    output logic             en_execute,
    output logic             en_memory,
    output logic             en_writeback,
    output logic             en_pcupd,
    output logic [2:0]       stat,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    stage_e            state_reg, state_next;
    logic [63:0]       pc_reg, pc_next;
    logic [2:0]        stat_reg, stat_next;
    logic [WAIT_W-1:0] wait_reg;
    logic              clear_cnt;
    logic [2:0]        fetch_stat;

    // The fetch flags already summarise the icode; it is not decoded here.
    logic unused_icode;
    assign unused_icode = ^f_icode;

    assign fetch_stat = fetch_status(f_imem_er, f_inst_valid, f_hlt_er);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            stat_reg  <= STAT_AOK;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            stat_reg  <= stat_next;
            if (state_reg == ST_MEMORY && state_next == ST_MEMORY)
                wait_reg <= wait_reg + WAIT_W'(1);
            else
                wait_reg <= '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        stat_next  = stat_reg;
        clear_cnt  = 1'b0;
        unique case (state_reg)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_next = ST_FETCH;
                    pc_next    = start_pc;
                    stat_next  = STAT_AOK;
                    clear_cnt  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (fetch_stat != STAT_AOK) begin
                    stat_next  = fetch_stat;
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE:  state_next = ST_EXECUTE;
            ST_EXECUTE: state_next = ST_MEMORY;
            ST_MEMORY: begin
                // A ready arriving on the final allowed cycle beats the timeout.
                if (!mem_access) begin
                    state_next = ST_WRITEBACK;
                end else if (dmem_ready) begin
                    if (dmem_er) begin
                        stat_next  = STAT_ADR;
                        state_next = ST_HALT;
                    end else begin
                        state_next = ST_WRITEBACK;
                    end
                end else if (wait_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    stat_next  = STAT_ADR;
                    state_next = ST_HALT;
                end
            end
            ST_WRITEBACK: state_next = ST_PCUPD;
            ST_PCUPD: begin
                pc_next    = new_pc;
                state_next = ST_FETCH;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign en_fetch     = (state_reg == ST_FETCH);
    assign en_decode    = (state_reg == ST_DECODE);
    assign en_execute   = (state_reg == ST_EXECUTE);
    assign en_memory    = (state_reg == ST_MEMORY);
    assign en_writeback = (state_reg == ST_WRITEBACK);
    assign en_pcupd     = (state_reg == ST_PCUPD);
    assign halted       = (state_reg == ST_HALT);
    assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
    assign pc           = pc_reg;
    assign stat         = stat_reg;

    seq_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_cnt),
        .inc_cycle  (busy),
        .inc_instr  (en_pcupd),
        .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboard bench for seq_stage_controller: a driver plays instruction
// descriptors and a per-instruction outcome model; a monitor checks each retirement or halt.
module tb_seq_stage_controller;

    localparam logic [63:0] RESET_PC    = 64'h0;
    localparam int          MEM_TIMEOUT = 16;
    localparam int          CNT_W       = 32;
    localparam logic [2:0]  AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [63:0]      start_pc = '0;
    logic [3:0]       f_icode = '0;
    logic             f_inst_valid = 1'b0;
    logic             f_imem_er = 1'b0;
    logic             f_hlt_er = 1'b0;
    logic             mem_access = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             dmem_er = 1'b0;
    logic [63:0]      new_pc = '0;
    logic [63:0]      pc;
    logic             en_fetch, en_decode, en_execute, en_memory, en_writeback, en_pcupd;
    logic [2:0]       stat;
    logic             busy, halted;
    logic [CNT_W-1:0] cycle_count, instr_count;

    seq_stage_controller #(
        .RESET_PC   (RESET_PC),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_pc    (start_pc),
        .f_icode     (f_icode),
        .f_inst_valid(f_inst_valid),
        .f_imem_er   (f_imem_er),
        .f_hlt_er    (f_hlt_er),
        .mem_access  (mem_access),
        .dmem_ready  (dmem_ready),
        .dmem_er     (dmem_er),
        .new_pc      (new_pc),
        .pc          (pc),
        .en_fetch    (en_fetch),
        .en_decode   (en_decode),
        .en_execute  (en_execute),
        .en_memory   (en_memory),
        .en_writeback(en_writeback),
        .en_pcupd    (en_pcupd),
        .stat        (stat),
        .busy        (busy),
        .halted      (halted),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // One instruction as the environment presents it; dly = wait cycles before ready.
    typedef struct {
        bit          imem;
        bit          valid;
        bit          hlt;
        bit          mem;
        int          dly;
        bit          er;
        logic [63:0] npc;
    } desc_t;

    typedef struct {
        logic [63:0] pc;
        logic [2:0]  stat;
        int          ic;
        int          cyc;
        int          mem_n;
        int          wb;
    } exp_t;

    desc_t prog_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    txn = 0;

    logic [63:0] m_pc;
    logic [2:0]  m_stat;
    int          m_ic, m_cyc;
    int          cur_dly;
    bit          cur_er;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic desc_t mk(bit imem, bit valid, bit hlt, bit mem, int dly, bit er,
                                 logic [63:0] npc);
        desc_t d;
        d.imem = imem; d.valid = valid; d.hlt = hlt;
        d.mem = mem; d.dly = dly; d.er = er; d.npc = npc;
        return d;
    endfunction

    function automatic desc_t rnd_desc();
        return mk($urandom_range(0, 11) == 0, $urandom_range(0, 11) != 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 20)), $urandom_range(0, 5) == 0,
                  {$urandom, $urandom});
    endfunction

    // Outcome of one instruction from stage-count arithmetic.
    task automatic model_step(input desc_t d);
        exp_t       e;
        logic [2:0] f;
        f = d.imem ? ADR : (!d.valid ? INS : (d.hlt ? HLT : AOK));
        e.mem_n = 0;
        e.wb    = 0;
        if (f != AOK) begin
            m_cyc += 1;
            m_stat = f;
        end else if (!d.mem) begin
            m_cyc += 6; m_pc = d.npc; m_ic++;
            e.mem_n = 1; e.wb = 1;
        end else if (d.dly < MEM_TIMEOUT) begin
            e.mem_n = d.dly + 1;
            if (d.er) begin
                m_cyc += 3 + d.dly + 1;
                m_stat = ADR;
            end else begin
                m_cyc += 5 + d.dly + 1; m_pc = d.npc; m_ic++;
                e.wb = 1;
            end
        end else begin
            m_cyc += 3 + MEM_TIMEOUT;
            m_stat = ADR;
            e.mem_n = MEM_TIMEOUT;
        end
        e.pc = m_pc; e.stat = m_stat; e.ic = m_ic; e.cyc = m_cyc;
        exp_q.push_back(e);
    endtask

    initial begin : driver
        int    mem_k;
        desc_t d;
        mem_k = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_k = 0; dmem_ready = 1'b0; dmem_er = 1'b0;
                continue;
            end
            if (en_fetch) begin
                if (prog_q.size() > 0) d = prog_q.pop_front();
                else d = mk(0, 1, 1, 0, 0, 0, 64'h0);
                f_imem_er = d.imem; f_inst_valid = d.valid; f_hlt_er = d.hlt;
                f_icode = d.hlt ? 4'h0 : 4'h6;
                mem_access = d.mem; new_pc = d.npc;
                cur_dly = d.dly; cur_er = d.er;
                model_step(d);
            end
            if (en_memory && mem_access) begin
                dmem_ready = (mem_k == cur_dly);
                dmem_er = dmem_ready & cur_er;
                mem_k++;
            end else begin
                mem_k = 0; dmem_ready = 1'b0; dmem_er = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit   prev_pcupd, prev_halted;
        int   mem_n, wb_n, pu_n, hot;
        exp_t e;
        prev_pcupd = 0; prev_halted = 0; mem_n = 0; wb_n = 0; pu_n = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pcupd = 0; prev_halted = 0; mem_n = 0; wb_n = 0; pu_n = 0;
                continue;
            end
            hot = int'(en_fetch) + int'(en_decode) + int'(en_execute) + int'(en_memory)
                + int'(en_writeback) + int'(en_pcupd);
            check("onehot", 64'(hot), busy ? 64'd1 : 64'd0);
            if (prev_pcupd || (halted && !prev_halted)) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: got an instruction end, required a pending expectation");
                end else begin
                    e = exp_q.pop_front();
                    txn++;
                    $display("txn %0d: pc=%0h stat=%0d instr=%0d cycles=%0d mem=%0d wb=%0d",
                             txn, pc, stat, instr_count, cycle_count, mem_n, wb_n);
                    check("txn_pc", pc, e.pc);
                    check("txn_stat", 64'(stat), 64'(e.stat));
                    check("txn_instr", 64'(instr_count), 64'(e.ic));
                    check("txn_cycles", 64'(cycle_count), 64'(e.cyc));
                    check("txn_mem_cycles", 64'(mem_n), 64'(e.mem_n));
                    check("txn_writeback", 64'(wb_n), 64'(e.wb));
                    check("txn_pcupd", 64'(pu_n), 64'(e.wb));
                end
            end
            if (en_fetch) begin mem_n = 0; wb_n = 0; pu_n = 0; end
            if (en_memory) mem_n++;
            if (en_writeback) wb_n++;
            if (en_pcupd) pu_n++;
            prev_pcupd = en_pcupd;
            prev_halted = halted;
        end
    end

    task automatic start_run(input logic [63:0] spc);
        m_pc = spc; m_stat = AOK; m_ic = 0; m_cyc = 0;
        start = 1'b1; start_pc = spc;
        @(negedge clk);
        start = 1'b0;
        check("start_pc", pc, spc);
        check("start_stat", 64'(stat), 64'(AOK));
        check("start_cycles", 64'(cycle_count), 64'd0);
        check("start_instr", 64'(instr_count), 64'd0);
        check("start_busy", 64'(busy), 64'd1);
    endtask

    task automatic finish_run(input bit poke_start);
        int n;
        n = 0;
        if (poke_start) begin
            while (!en_decode && !halted && n < 20) begin @(negedge clk); n++; end
            if (en_decode) begin
                start = 1'b1; start_pc = 64'hDEAD_BEEF;
                @(negedge clk);
                start = 1'b0;
            end
        end
        n = 0;
        while (!halted && n < 3000) begin @(negedge clk); n++; end
        if (!halted) begin
            checks++; errors++;
            $display("FAIL halt_wait: got no halt in %0d cycles, required halt", n);
        end
        @(negedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        prog_q.delete();
        exp_q.delete();
    endtask

    initial begin : stimulus
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, RESET_PC);
        check("rst_stat", 64'(stat), 64'(AOK));
        check("rst_cycles", 64'(cycle_count), 64'd0);
        check("rst_instr", 64'(instr_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_enables", 64'({en_fetch, en_decode, en_execute, en_memory, en_writeback, en_pcupd}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // irmovq, irmovq, addq, halt at 0x16
        prog_q.push_back(mk(0, 1, 0, 0, 0, 0, 64'd10));
        prog_q.push_back(mk(0, 1, 0, 0, 0, 0, 64'd20));
        prog_q.push_back(mk(0, 1, 0, 0, 0, 0, 64'd22));
        prog_q.push_back(mk(0, 1, 1, 0, 0, 0, 64'd0));
        start_run(64'd0);
        finish_run(1);
        check("prog_pc", pc, 64'd22);
        check("prog_stat", 64'(stat), 64'(HLT));
        check("prog_halted", 64'(halted), 64'd1);
        check("prog_instr", 64'(instr_count), 64'd3);
        check("prog_cycles", 64'(cycle_count), 64'd19);

        prog_q.push_back(mk(0, 0, 0, 0, 0, 0, 64'h99));
        start_run(64'h40);
        finish_run(0);
        check("ins_stat", 64'(stat), 64'(INS));
        check("ins_pc", pc, 64'h40);
        check("ins_instr", 64'(instr_count), 64'd0);

        prog_q.push_back(mk(0, 1, 0, 1, 3, 0, 64'h50));
        prog_q.push_back(mk(0, 1, 1, 0, 0, 0, 64'h0));
        start_run(64'h10);
        finish_run(0);
        check("memwait_cycles", 64'(cycle_count), 64'd10);

        prog_q.push_back(mk(0, 1, 0, 1, 1000, 0, 64'h60));
        start_run(64'h20);
        finish_run(0);
        check("timeout_stat", 64'(stat), 64'(ADR));
        check("timeout_cycles", 64'(cycle_count), 64'd19);
        check("timeout_pc", pc, 64'h20);

        prog_q.push_back(mk(1, 1, 1, 0, 0, 0, 64'h0));
        start_run(64'h30);
        finish_run(0);
        check("prio_stat", 64'(stat), 64'(ADR));

        // Ready on the last allowed cycle, then one cycle too late, then dmem error.
        prog_q.push_back(mk(0, 1, 0, 1, MEM_TIMEOUT - 1, 0, 64'h70));
        prog_q.push_back(mk(0, 1, 0, 1, MEM_TIMEOUT, 0, 64'h80));
        start_run(64'h0);
        finish_run(0);
        check("edge_pc", pc, 64'h70);
        check("edge_stat", 64'(stat), 64'(ADR));

        prog_q.push_back(mk(0, 1, 0, 1, 2, 1, 64'h90));
        start_run(64'h8);
        finish_run(0);
        check("dmem_er_stat", 64'(stat), 64'(ADR));

        // Reset during EXECUTE of the third instruction.
        prog_q.push_back(mk(0, 1, 0, 0, 0, 0, 64'h100));
        prog_q.push_back(mk(0, 1, 0, 0, 0, 0, 64'h200));
        prog_q.push_back(mk(0, 1, 0, 1, 5, 0, 64'h300));
        start_run(64'h0);
        n = 0;
        while (!(en_execute && instr_count == 2) && n < 200) begin @(negedge clk); n++; end
        if (!(en_execute && instr_count == 2)) begin
            checks++; errors++;
            $display("FAIL exec_wait: got no EXECUTE of instruction 3, required one");
        end
        #2 rst = 1'b1;
        #1;
        check("arst_pc", pc, RESET_PC);
        check("arst_cycles", 64'(cycle_count), 64'd0);
        check("arst_instr", 64'(instr_count), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_stat", 64'(stat), 64'(AOK));
        prog_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int p = 0; p < 25; p++) begin
            int len;
            desc_t d;
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) prog_q.push_back(rnd_desc());
            d = rnd_desc();
            d.hlt = 1'b1;
            prog_q.push_back(d);
            start_run({$urandom, $urandom});
            finish_run(p % 3 == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_stage_controller.md
Name: seq_stage_controller

Overview:
Multi-cycle sequencer for the Y86-64 SEQ core. Owns the architectural PC and status register. Steps one instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPDATE, issuing one-hot stage enables. Waits on a data-memory ready handshake with timeout, latches fetch/memory exceptions into Y86 status codes, and keeps cycle/retired-instruction counters.

Parameters:
RESET_PC, 0, PC value loaded on reset
MEM_TIMEOUT, 16, max cycles in MEMORY waiting for dmem_ready before ADR fault (>=1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin execution at start_pc; honoured only in IDLE or HALT
start_pc  in  64  initial PC loaded on accepted start
f_icode  in  4  icode from fetch stage
f_inst_valid  in  1  fetch: instruction valid
f_imem_er  in  1  fetch: instruction address out of range
f_hlt_er  in  1  fetch: halt encountered
mem_access  in  1  current instruction uses data memory (from decode/execute)
dmem_ready  in  1  data memory completed access this cycle
dmem_er  in  1  data memory address error, sampled with dmem_ready
new_pc  in  64  next PC from PC-select logic
pc  out  64  architectural PC
en_fetch, en_decode, en_execute, en_memory, en_writeback, en_pcupd  out  1 each  one-hot stage enables
stat  out  3  Y86 status: AOK=1, HLT=2, ADR=3, INS=4
busy  out  1  high in any state other than IDLE and HALT
halted  out  1  high in HALT
cycle_count  out  CNT_W  busy cycles since last start
instr_count  out  CNT_W  instructions retired (PCUPDATE completions)

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, stat=AOK, counters=0, all enables 0, busy=0, halted=0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT. Enables decoded from registered state; exactly one high in FETCH..PCUPD, none in IDLE/HALT.
- IDLE/HALT + start: pc<=start_pc, stat<=AOK, counters<=0, next FETCH. Start in other states is ignored.
- FETCH: sample fetch status with priority f_imem_er > !f_inst_valid > f_hlt_er. Record ADR, INS or HLT respectively and go to HALT with pc unchanged. Otherwise go to DECODE.
- DECODE -> EXECUTE -> MEMORY, one cycle each.
- MEMORY, mem_access=0: one cycle, then WRITEBACK.
- MEMORY, mem_access=1: stay until dmem_ready=1.
  - dmem_er=1 with ready: stat<=ADR, go HALT, skip WRITEBACK.
  - Otherwise go WRITEBACK.
  - Wait counter reaching MEM_TIMEOUT cycles without ready: stat<=ADR, go HALT.
  - dmem_ready in the same cycle the timeout is reached: ready wins.
- WRITEBACK -> PCUPD. PCUPD: pc<=new_pc, instr_count++, next FETCH.
- Fault paths never assert en_writeback or en_pcupd. Faulting/halting instruction is not counted.
- cycle_count increments on every busy cycle. Both counters saturate at all-ones (no wrap).
- HALT holds pc, stat and counters until start or rst.
- rst asserted mid-instruction aborts immediately to reset values. No partial writeback is owed.
- new_pc is taken unmodified. An out-of-range value is detected by fetch next cycle (imem_er -> ADR).

Decomposition:
- Shared package y86_pkg: STAT_AOK/HLT/ADR/INS constants, icode constants (I_HALT=0 .. I_POPQ=11), stage-state encoding.
- One sub-module: seq_perf_counters (two saturating CNT_W counters with inc/clear inputs).

Test Plan:
- Program at 0: irmovq $4,%rax (10B), irmovq $10,%rbx (10B), addq (2B), halt at 22; start_pc=0, mem_access=0 -> pc sequence 0,10,20,22; stat=HLT; halted=1; instr_count=3; cycle_count=19.
- Fetch reports f_inst_valid=0 at pc=0x40 -> stat=INS, pc stays 0x40, no en_writeback/en_pcupd pulse, instr_count unchanged.
- mem_access=1, dmem_ready after 3 wait cycles, dmem_er=0 -> MEMORY occupied 4 cycles, then WRITEBACK; cycle_count for that instruction = 9.
- mem_access=1, dmem_ready never asserted, MEM_TIMEOUT=16 -> stat=ADR after 16 MEMORY cycles, halted=1, no writeback.
- Simultaneous f_imem_er=1 and f_hlt_er=1 -> stat=ADR (priority check).
- rst pulsed while in EXECUTE -> pc=RESET_PC, state IDLE, counters 0 within the same cycle; start during busy ignored, start in HALT restarts with counters cleared.
